// File: rtl/maria_pkg.sv
// Shared types and sizing for the MARIA bus arbiter.
package maria_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HALT_WAIT = 2'd1,
    GRANT     = 2'd2,
    TURN      = 2'd3
  } arb_state_t;

  localparam int DMA_MAX_DEF = 454;
  localparam int DMA_MAX_W   = $clog2(DMA_MAX_DEF + 1);

endpackage

// File: rtl/maria_bus_arbiter.sv
// Shares the 7800 address bus between the 6502C and MARIA line DMA:
// HALT, grant, turnaround and release sequencing plus the WSYNC hold on RDY.
module maria_bus_arbiter
  import maria_pkg::*;
#(
  parameter int HALT_CYCLES = 2,
  parameter int TURNAROUND  = 1,
  parameter int DMA_MAX     = DMA_MAX_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        mclk0,
  input  logic        pclkp,
  input  logic        maria_en,
  input  logic        wsync,
  input  logic        line_start,
  input  logic        dma_req,
  input  logic        dma_done,
  input  logic [15:0] dma_ab,
  input  logic [15:0] cpu_ab,
  input  logic        cpu_rw,
  output logic [15:0] AB,
  output logic        RW,
  output logic        ABEN,
  output logic        drive_AB,
  output logic        halt_n,
  output logic        rdy,
  output logic        dma_grant,
  output logic        overrun
);

  localparam int CNT_W = $clog2(DMA_MAX + 1);
  localparam logic [CNT_W-1:0] HALT_LAST = CNT_W'(HALT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURNAROUND - 1);
  localparam logic [CNT_W-1:0] DMA_LAST  = CNT_W'(DMA_MAX - 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_evt;
  logic             force_rel;

  // One counter serves all states: pclkp strobes while halting, mclk0 ticks otherwise.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cnt_evt   = 1'b0;
    force_rel = 1'b0;
    case (state_q)
      IDLE: if (dma_req) state_d = HALT_WAIT;
      HALT_WAIT: begin
        cnt_evt = pclkp;
        if (!dma_req)                        state_d = TURN;
        else if (pclkp && cnt_q == HALT_LAST) state_d = GRANT;
      end
      GRANT: begin
        cnt_evt = mclk0;
        if (dma_done) state_d = TURN;
        else if (mclk0 && cnt_q == DMA_LAST) begin
          state_d   = TURN;
          force_rel = 1'b1;
        end
      end
      TURN: begin
        cnt_evt = mclk0;
        if (mclk0 && cnt_q == TURN_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!maria_en) begin
      state_d   = IDLE;
      force_rel = 1'b0;
    end
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_evt)       cnt_d = cnt_q + 1'b1;
  end

  // Bus-control outputs are registered from the next state so they change on the transition edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      halt_n    <= 1'b1;
      rdy       <= 1'b1;
      dma_grant <= 1'b0;
      drive_AB  <= 1'b0;
      ABEN      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      halt_n    <= (state_d == IDLE);
      dma_grant <= (state_d == GRANT);
      drive_AB  <= (state_d == GRANT);
      ABEN      <= (state_d == GRANT);
      if (force_rel) overrun <= 1'b1;
      // wsync beats a coincident line_start so the hold lasts a full line.
      if (!maria_en)       rdy <= 1'b1;
      else if (wsync)      rdy <= 1'b0;
      else if (line_start) rdy <= 1'b1;
    end
  end

  assign AB = (state_q == GRANT) ? dma_ab : cpu_ab;
  assign RW = (state_q == GRANT) ? 1'b1   : cpu_rw;

endmodule
